// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets, CTRL/STATUS bit
// positions and default configuration.
package mmio_pkg;

    localparam logic [7:0] DEFAULT_BASE       = 8'hF8;
    localparam int         DEFAULT_FIFO_DEPTH = 4;

    localparam logic [2:0] OFF_SW   = 3'd0;
    localparam logic [2:0] OFF_LED  = 3'd1;
    localparam logic [2:0] OFF_TLO  = 3'd2;
    localparam logic [2:0] OFF_THI  = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;
    localparam logic [2:0] OFF_CMP  = 3'd5;
    localparam logic [2:0] OFF_FIFO = 3'd6;
    localparam logic [2:0] OFF_STAT = 3'd7;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLR_BIT   = 1;
    localparam int CTRL_MATCH_BIT = 7;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_CNT_LSB   = 2;
    localparam int STAT_OVF_BIT   = 5;

endpackage

// File: rtl/mmio_responder_if.sv
// Data-memory port as seen by the MMIO responder: datapath request in,
// registered read data and hit flag out.
interface mmio_responder_if;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] address;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       hit;

    modport master (output mem_read, output mem_write, output address, output wdata,
                    input rdata, input hit);
    modport slave  (input mem_read, input mem_write, input address, input wdata,
                    output rdata, output hit);
endinterface

// File: rtl/mmio_fifo.sv
// Byte FIFO with combinational head; push while full or pop while empty is
// simply not performed, the drop policy belongs to the caller.
module mmio_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [7:0]    data_arr [DEPTH];
    logic          do_push, do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Entries are cleared by reset so stale bytes never reappear after a restart.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [7:0] entry_reg;
        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                entry_reg <= 8'h00;
            else if (do_push && wr_ptr_reg == AW'(gi))
                entry_reg <= push_data;
        end
        assign data_arr[gi] = entry_reg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = data_arr[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/mmio_responder.sv
// Eight-byte MMIO window next to the data RAM: switches, LEDs, optional timer
// (MMIO_TIMER_EN) and a byte output FIFO, read back with one-cycle latency.
module mmio_responder import mmio_pkg::*; #(
    parameter logic [7:0] BASE       = DEFAULT_BASE,
    parameter int         FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    mmio_responder_if.slave   bus,
    input  logic [2:0]        sw_in,
    output logic [7:0]        ledg_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic       sel, wr_sel, rd_sel;
    logic [2:0] offset;
    logic [2:0] sw_meta_reg, sw_sync_reg;
    logic [7:0] led_reg, rdata_reg, rd_val, stat_val, ctrl_val;
    logic [7:0] tlo_val, thi_val, cmp_val;
    logic       hit_reg, overflow_reg;
    logic       fifo_full, fifo_empty, fifo_pop, push_req, ovf_set;
    logic [CW-1:0] fifo_count;
    logic [2:0] count3;
    logic       ctrl_en, ctrl_match;

    assign sel    = (bus.address[7:3] == BASE[7:3]);
    assign offset = bus.address[2:0];
    assign wr_sel = bus.mem_write & sel;
    assign rd_sel = bus.mem_read & sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
            led_reg     <= '0;
        end else begin
            sw_meta_reg <= sw_in;
            sw_sync_reg <= sw_meta_reg;
            if (wr_sel && offset == OFF_LED) led_reg <= bus.wdata;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifo_pop = ~fifo_empty & tx_ready;
    assign push_req = wr_sel && offset == OFF_FIFO;
    assign ovf_set  = push_req & fifo_full & ~fifo_pop;

    mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (bus.wdata),
        .pop       (fifo_pop),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = ~fifo_empty;
    assign count3   = 3'(fifo_count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            overflow_reg <= 1'b0;
        else if (ovf_set)
            overflow_reg <= 1'b1;
        else if (rd_sel && offset == OFF_STAT)
            overflow_reg <= 1'b0;
    end

`ifdef MMIO_TIMER_EN
    logic [15:0] timer_reg;
    logic [7:0]  snapshot_reg, compare_reg;
    logic        enable_reg, match_reg, ctrl_wr;

    assign ctrl_wr = wr_sel && offset == OFF_CTRL;

    // Clear beats increment; a new match beats a write-1-to-clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_reg    <= '0;
            snapshot_reg <= '0;
            compare_reg  <= 8'hFF;
            enable_reg   <= 1'b0;
            match_reg    <= 1'b0;
        end else begin
            if (ctrl_wr && bus.wdata[CTRL_CLR_BIT])
                timer_reg <= '0;
            else if (enable_reg)
                timer_reg <= timer_reg + 16'd1;
            if (ctrl_wr) enable_reg <= bus.wdata[CTRL_EN_BIT];
            if (wr_sel && offset == OFF_CMP) compare_reg <= bus.wdata;
            if (rd_sel && offset == OFF_TLO) snapshot_reg <= timer_reg[15:8];
            if (enable_reg && timer_reg[7:0] == compare_reg)
                match_reg <= 1'b1;
            else if (ctrl_wr && bus.wdata[CTRL_MATCH_BIT])
                match_reg <= 1'b0;
        end
    end

    assign tlo_val    = timer_reg[7:0];
    assign thi_val    = snapshot_reg;
    assign cmp_val    = compare_reg;
    assign ctrl_en    = enable_reg;
    assign ctrl_match = match_reg;
`else
    assign tlo_val    = 8'h00;
    assign thi_val    = 8'h00;
    assign cmp_val    = 8'h00;
    assign ctrl_en    = 1'b0;
    assign ctrl_match = 1'b0;
`endif

    always_comb begin
        ctrl_val                 = 8'h00;
        ctrl_val[CTRL_EN_BIT]    = ctrl_en;
        ctrl_val[CTRL_MATCH_BIT] = ctrl_match;
        stat_val                        = 8'h00;
        stat_val[STAT_EMPTY_BIT]        = fifo_empty;
        stat_val[STAT_FULL_BIT]         = fifo_full;
        stat_val[STAT_CNT_LSB +: 3]     = count3;
        stat_val[STAT_OVF_BIT]          = overflow_reg;
    end

    always_comb begin
        rd_val = 8'h00;
        case (offset)
            OFF_SW:   rd_val = {5'b0, sw_sync_reg};
            OFF_LED:  rd_val = led_reg;
            OFF_TLO:  rd_val = tlo_val;
            OFF_THI:  rd_val = thi_val;
            OFF_CTRL: rd_val = ctrl_val;
            OFF_CMP:  rd_val = cmp_val;
            OFF_FIFO: rd_val = {5'b0, count3};
            OFF_STAT: rd_val = stat_val;
            default:  rd_val = 8'h00;
        endcase
    end

    // Read data is captured from pre-write state, so a combined read/write sees the old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_reg <= 8'h00;
            hit_reg   <= 1'b0;
        end else if (bus.mem_read) begin
            hit_reg   <= sel;
            rdata_reg <= sel ? rd_val : 8'h00;
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.hit   = hit_reg;
    assign ledg_out  = led_reg;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed plus randomized bench for mmio_responder against a transaction-level
// model of the register map, timer and FIFO.
module tb_mmio_responder;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] sw_in;
    logic [7:0] ledg_out, tx_data;
    logic       tx_valid, tx_ready;

    int vectors = 0;
    int miscompares = 0;

    mmio_responder_if bus();

    mmio_responder #(.BASE(8'hF8), .FIFO_DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .sw_in    (sw_in),
        .ledg_out (ledg_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clock = ~clock;

    // Reference state
    logic [7:0]  m_led, m_cmp, m_snap, m_rdata;
    logic        m_hit, m_en, m_match, m_ovf;
    logic [15:0] m_timer;
    logic [2:0]  m_s1, m_s2;
    logic [7:0]  fq[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led = 8'h00; m_cmp = 8'hFF; m_snap = 8'h00; m_rdata = 8'h00;
        m_hit = 1'b0; m_en = 1'b0; m_match = 1'b0; m_ovf = 1'b0;
        m_timer = 16'h0000; m_s1 = 3'b0; m_s2 = 3'b0;
        fq.delete();
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] off);
        int n;
        n = fq.size();
`ifndef MMIO_TIMER_EN
        if (off inside {[3'd2:3'd5]}) return 8'h00;
`endif
        case (off)
            3'd0: return {5'b0, m_s2};
            3'd1: return m_led;
            3'd2: return m_timer[7:0];
            3'd3: return m_snap;
            3'd4: return {m_match, 6'b0, m_en};
            3'd5: return m_cmp;
            3'd6: return 8'(n);
            default: return {2'b0, m_ovf, 3'(n), n == DEPTH, n == 0};
        endcase
    endfunction

    // One clock of stimulus: the model advances from pre-edge state, then outputs are checked.
    task automatic cycle(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wd, input logic rdy, input logic [2:0] sw);
        logic sel, pop, push_req, ovf_set;
        logic [2:0] off;
        logic [7:0] rv, tmp;
        int n;
        bus.mem_read = rd; bus.mem_write = wr; bus.address = addr; bus.wdata = wd;
        tx_ready = rdy; sw_in = sw;
        sel = (addr[7:3] == 5'h1F);
        off = addr[2:0];
        rv = model_read(off);
        n = fq.size();
        pop = (n != 0) && rdy;
        push_req = wr && sel && off == 3'd6;
        ovf_set = 1'b0;
        if (pop) tmp = fq.pop_front();
        if (push_req) begin
            if (n < DEPTH || pop) fq.push_back(wd);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (rd && sel && off == 3'd7) m_ovf = 1'b0;
        if (wr && sel && off == 3'd1) m_led = wd;
`ifdef MMIO_TIMER_EN
        begin
            logic        nm;
            logic [15:0] nt;
            nm = (m_en && m_timer[7:0] == m_cmp) ? 1'b1 :
                 ((wr && sel && off == 3'd4 && wd[7]) ? 1'b0 : m_match);
            nt = (wr && sel && off == 3'd4 && wd[1]) ? 16'h0 : m_timer + (m_en ? 16'd1 : 16'd0);
            if (rd && sel && off == 3'd2) m_snap = m_timer[15:8];
            if (wr && sel && off == 3'd4) m_en = wd[0];
            if (wr && sel && off == 3'd5) m_cmp = wd;
            m_timer = nt;
            m_match = nm;
        end
`endif
        if (rd) begin m_hit = sel; m_rdata = sel ? rv : 8'h00; end
        m_s2 = m_s1; m_s1 = sw;
        @(posedge clock); #1;
        check("hit", 16'(bus.hit), 16'(m_hit));
        if (m_hit) check("rdata", 16'(bus.rdata), 16'(m_rdata));
        check("ledg_out", 16'(ledg_out), 16'(m_led));
        check("tx_valid", 16'(tx_valid), 16'(fq.size() != 0));
        if (fq.size() != 0) check("tx_data", 16'(tx_data), 16'(fq[0]));
        if (rd || wr)
            $display("t=%0t rd=%b wr=%b addr=%02h wdata=%02h -> rdata=%02h hit=%b tx_valid=%b",
                     $time, rd, wr, addr, wd, bus.rdata, bus.hit, tx_valid);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b0);
    endtask

    task automatic reset_pulse();
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; tx_ready = 1'b0; sw_in = 3'b0;
        reset = 1'b1;
        #1;
        check("rst_tx_valid", 16'(tx_valid), 16'h0);
        check("rst_hit", 16'(bus.hit), 16'h0);
        check("rst_rdata", 16'(bus.rdata), 16'h0);
        check("rst_ledg", 16'(ledg_out), 16'h0);
        model_reset();
        @(posedge clock); #2;
        reset = 1'b0;
    endtask

    initial begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.address = 8'h00; bus.wdata = 8'h00;
        tx_ready = 1'b0; sw_in = 3'b0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset_pulse();

        // Register map after reset
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'hF8 + 8'(i), 8'h00, 1'b0, 3'b0);
        cycle(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'b0);
        check("stat_reset", 16'(bus.rdata), 16'h01);

        // LED write and readback, then an unselected read
        cycle(1'b0, 1'b1, 8'hF9, 8'hA5, 1'b0, 3'b0);
        check("led_a5", 16'(ledg_out), 16'hA5);
        cycle(1'b1, 1'b0, 8'hF9, 8'h00, 1'b0, 3'b0);
        check("led_read", 16'(bus.rdata), 16'hA5);
        cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 3'b0);
        check("miss_hit", 16'(bus.hit), 16'h0);

        // Switch synchronizer latency
        cycle(1'b1, 1'b0, 8'hF8, 8'h00, 1'b0, 3'd5);
        cycle(1'b1, 1'b0, 8'hF8, 8'h00, 1'b0, 3'd5);
        cycle(1'b1, 1'b0, 8'hF8, 8'h00, 1'b0, 3'd5);
        check("sw_sync", 16'(bus.rdata), 16'h05);

`ifdef MMIO_TIMER_EN
        cycle(1'b0, 1'b1, 8'hFC, 8'h01, 1'b0, 3'b0);
        idle(300);
        cycle(1'b1, 1'b0, 8'hFA, 8'h00, 1'b0, 3'b0);
        cycle(1'b1, 1'b0, 8'hFB, 8'h00, 1'b0, 3'b0);
        cycle(1'b0, 1'b1, 8'hFC, 8'h02, 1'b0, 3'b0);
        cycle(1'b1, 1'b0, 8'hFA, 8'h00, 1'b0, 3'b0);
        check("timer_clear", 16'(bus.rdata), 16'h00);

        cycle(1'b0, 1'b1, 8'hFD, 8'h05, 1'b0, 3'b0);
        cycle(1'b0, 1'b1, 8'hFC, 8'h03, 1'b0, 3'b0);
        for (int k = 0; k < 300 && m_timer[7:0] != 8'h05; k++) idle(1);
        idle(1);
        cycle(1'b1, 1'b0, 8'hFC, 8'h00, 1'b0, 3'b0);
        check("match_set", 16'(bus.rdata[7]), 16'h1);
        cycle(1'b0, 1'b1, 8'hFC, 8'h81, 1'b0, 3'b0);
        cycle(1'b1, 1'b0, 8'hFC, 8'h00, 1'b0, 3'b0);
        check("match_clear", 16'(bus.rdata[7]), 16'h0);
        for (int k = 0; k < 300 && m_timer[7:0] != 8'h05; k++) idle(1);
        cycle(1'b0, 1'b1, 8'hFC, 8'h81, 1'b0, 3'b0);
        cycle(1'b1, 1'b0, 8'hFC, 8'h00, 1'b0, 3'b0);
        check("match_set_wins", 16'(bus.rdata[7]), 16'h1);
`endif

        // FIFO overflow, drain and STATUS clear
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 8'hFE, 8'(i), 1'b0, 3'b0);
        cycle(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'b0);
        check("stat_overflow", 16'(bus.rdata), 16'h32);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'b0);
        cycle(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'b0);
        check("stat_drained", 16'(bus.rdata), 16'h01);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hFE, 8'h40 + 8'(i), 1'b0, 3'b0);
        cycle(1'b0, 1'b1, 8'hFE, 8'h77, 1'b1, 3'b0);
        cycle(1'b1, 1'b0, 8'hFE, 8'h00, 1'b0, 3'b0);
        check("count_pushpop", 16'(bus.rdata), 16'h04);
        cycle(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'b0);
        check("no_overflow", 16'(bus.rdata[5]), 16'h0);

        reset_pulse();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 9) < 8) ? (8'hF8 | 8'($urandom_range(0, 7))) : 8'($urandom);
            cycle(1'($urandom), 1'($urandom_range(0, 2) == 0), a, 8'($urandom),
                  1'($urandom), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the processor's data-memory port, alongside the data RAM. It decodes the top eight byte addresses (BASE..BASE+7) and answers reads with the same one-cycle registered latency as the synchronous RAM. Behind the port are a switch input, an LED register, a 16-bit cycle timer with compare flag, and a small output FIFO that streams bytes to a downstream consumer. The top level selects `rdata` over the RAM `q` whenever `hit` is high.

## Interface
- BASE, 8'hF8, first decoded address; low 3 bits must be 0
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..8

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_read  in  1  read strobe from datapath
- mem_write  in  1  write strobe from datapath
- address  in  8  byte address
- wdata  in  8  write data
- rdata  out  8  registered read data
- hit  out  1  registered; rdata is from this block
- sw_in  in  3  raw switch inputs
- ledg_out  out  8  LED register contents
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO not empty
- tx_ready  in  1  consumer accepts head this cycle

## Operation
- Decode: a request is selected when address[7:3] == BASE[7:3]. Offset is address[2:0].
- Register map (offset: access, contents):
  - 0: RO, {5'b0, sw_sync}. sw_sync passes through a two-flop synchronizer.
  - 1: RW, LED register.
  - 2: RO, timer[7:0]. The same read latches timer[15:8] into the snapshot.
  - 3: RO, snapshot.
  - 4: CTRL.
    - bit0 enable, RW.
    - bit1 clear, write-1 pulse, reads 0.
    - bit7 match, write 1 to clear.
  - 5: RW, compare value.
  - 6: write pushes wdata into the FIFO; read returns {5'b0, count}.
  - 7: RO, STATUS = {2'b0, overflow, count[2:0], full, empty}. Reading STATUS clears overflow.
- Reads of write-only or reserved bits return 0. Writes to RO offsets are ignored.
- Timer:
  - 16-bit counter that increments when enable is set, wrapping 16'hFFFF -> 0.
  - match is set when enable is high and timer[7:0] == compare. It is sticky.
- FIFO:
  - Push on a write to offset 6 when not full. A push while full drops the byte and sets overflow.
  - Pop when tx_valid && tx_ready.
  - tx_data is the head, combinational from FIFO storage.

## Timing
- Reset values: rdata=0, hit=0, ledg_out=0, tx_valid=0, timer=0, snapshot=0, compare=8'hFF, CTRL=0, overflow=0, FIFO empty, synchronizer flops=0.
- Read latency: mem_read sampled at edge N, so rdata and hit are valid after edge N and held until the next mem_read.
- hit is 0 after a read of an unselected address. Writes never change hit.
- Writes take effect at the sampling edge.
- mem_read and mem_write both high on a selected address: the write is performed, and rdata returns the pre-write value.
- Timer clear and increment in the same cycle: clear wins (timer=0). Set and clear of match in the same cycle: set wins.
- Push and pop in the same cycle when full: both occur, count unchanged, no overflow. When empty, only the push occurs.
- Overflow set and STATUS-read clear in the same cycle: rdata shows the old value, and overflow ends set.
- sw_in to a readable value: 2 cycles.
- Reset mid-operation clears all state asynchronously, including FIFO contents.

## Configuration
- MMIO_TIMER_EN defined: timer, snapshot, CTRL and compare are implemented as above.
- MMIO_TIMER_EN undefined:
  - Offsets 2–5 read 0 and writes to them are ignored.
  - The timer flops are not instantiated.
  - Offsets 2–5 still return hit=1.

## Structure
- Shared package mmio_pkg holds:
  - offset constants OFF_SW, OFF_LED, OFF_TLO, OFF_THI, OFF_CTRL, OFF_CMP, OFF_FIFO, OFF_STAT;
  - CTRL and STATUS bit-position constants;
  - the default BASE.
- One sub-module, mmio_fifo: a synchronous FIFO parameterized by depth, with push/pop/full/empty/count outputs and an overflow-free interface. The drop/overflow policy lives in the parent.

## Test plan
- Reset, then read offsets 0–7 at 8'hF8..FF → hit=1; rdata 0,0,0,0,0,8'hFF,0,8'h01 (sw_in held 0); ledg_out=0.
- Write 8'hA5 to F9; read F9 next cycle → ledg_out=8'hA5, rdata=8'hA5 one cycle after mem_read; read 8'h10 → hit=0.
- Write CTRL=1, wait 300 cycles, read FA then FB → 16-bit value within 2 cycles of the elapsed count; snapshot matches the high byte at the FA read; write CTRL=2 → timer 0 next cycle.
- Compare=8'h05, enable → CTRL bit7 set once timer[7:0]=5; write 8'h80 → cleared; simultaneous set+clear → remains 1.
- tx_ready=0, push 5 bytes 1..5 → STATUS=8'b00_1_100_1_0 (overflow, count 4, full); tx_ready=1 → tx_data 1,2,3,4 on consecutive cycles, then empty; next STATUS read clears overflow.
- Full FIFO with tx_ready=1 plus simultaneous push → count stays 4, overflow stays 0; assert reset mid-stream → tx_valid=0 immediately.
